ret_addr_stack: RTL

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/ret_addr_stack.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: return-address stack for a small CPU front end.
// A call pushes the return PC, a return pops it, and a simultaneous
// push+pop replaces the top entry (return immediately followed by a call).
// dout always shows the top entry, or zero when the stack is empty.
// ovf/unf are sticky error flags, cleared by clr_err or rst.
// Build option: define RET_ADDR_STACK_WRAP_EN to make a push on a full stack
// overwrite the oldest entry; by default such a push is dropped.
// Only ovf is raised on a full push in either build.
// Storage has no reset; dout is masked while empty, so unwritten entries never
// reach an output.

module ret_addr_stack #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               din,
   input  logic                           clr_err,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full,
   output logic                           ovf,
   output logic                           unf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    top_q, top_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             wr_en;
   logic [PW-1:0]    wr_addr;
   logic             ovf_set, unf_set;
   logic             is_empty, is_full;
   logic [PW-1:0]    top_inc, top_dec;

   // DEPTH is a power of two, so plain PW-bit arithmetic wraps modulo DEPTH.
   assign top_inc  = top_q + 1'b1;
   assign top_dec  = top_q - 1'b1;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));

   // Next-state decode: pointer, count, storage write and error events.
   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_addr = top_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;

      case ({push, pop})
         2'b10: begin
            if (!is_full) begin
               wr_en   = 1'b1;
               wr_addr = top_inc;
               top_d   = top_inc;
               count_d = count_q + 1'b1;
            end else begin
               ovf_set = 1'b1;
`ifdef RET_ADDR_STACK_WRAP_EN
               wr_en   = 1'b1;
               wr_addr = top_inc;
               top_d   = top_inc;
`endif
            end
         end
         2'b01: begin
            if (!is_empty) begin
               top_d   = top_dec;
               count_d = count_q - 1'b1;
            end else begin
               unf_set = 1'b1;
            end
         end
         2'b11: begin
            if (!is_empty) begin
               wr_en   = 1'b1;
               wr_addr = top_q;
            end else begin
               wr_en   = 1'b1;
               wr_addr = top_inc;
               top_d   = top_inc;
               count_d = CW'(1);
               unf_set = 1'b1;
            end
         end
         default: begin
         end
      endcase

      ovf_d = ovf_set | (ovf_q & ~clr_err);
      unf_d = unf_set | (unf_q & ~clr_err);
   end

   // Control state; rst overrides any operation or clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q   <= PW'(DEPTH - 1);
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage: never cleared, and writes are suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_addr] <= din;
      end
   end

   assign dout  = is_empty ? '0 : mem_q[top_q];
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule
